// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised echo UART.
// State encodings, parity modes and elaboration-time divisor arithmetic.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK_WAIT
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Data is zero-extended, which leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input parity_e mode);
    case (mode)
      PARITY_ODD:  return ~(^data);
      PARITY_EVEN: return ^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM and error pulses.
// Emits each good word with a single-cycle rx_valid strobe.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 err_frame,
  output logic                 err_parity
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam parity_e PMODE = parity_e'(2'(PARITY));

  logic                 rx_meta, rx_sync, rx_prev;
  rx_state_e            state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 bit_tick;

  assign bit_tick = (cnt == BIT_LAST);
  assign rx_data  = shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_err    <= 1'b0;
      rx_valid   <= 1'b0;
      err_frame  <= 1'b0;
      err_parity <= 1'b0;
    end else begin
      rx_meta    <= rs232_rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      rx_valid   <= 1'b0;
      err_frame  <= 1'b0;
      err_parity <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state   <= RX_START;
            cnt     <= '0;
            par_err <= 1'b0;
          end
        end
        RX_START: begin
          // A start bit that is high again by mid-bit was a glitch.
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_tick) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
            if (bit_idx == 4'(DATA_BITS - 1))
              state <= (PMODE == PARITY_NONE) ? RX_STOP : RX_PARITY;
            else
              bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (bit_tick) begin
            cnt     <= '0;
            par_err <= (rx_sync != parity_bit(MAX_DATA_BITS'(shreg), PMODE));
            state   <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // Framing error outranks parity error.
          if (bit_tick) begin
            cnt <= '0;
            if (!rx_sync) begin
              err_frame <= 1'b1;
              state     <= RX_BREAK_WAIT;
            end else if (par_err) begin
              err_parity <= 1'b1;
              state      <= RX_IDLE;
            end else begin
              rx_valid <= 1'b1;
              state    <= RX_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_BREAK_WAIT: begin
          if (!rx_sync) begin
            cnt <= '0;
          end else if (bit_tick) begin
            cnt   <= '0;
            state <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_param.sv
// Echo UART top: receiver, RX FIFO and transmitter re-sending buffered words.
// rx_valid is a push strobe with no back-pressure; a push into a full FIFO is dropped.
module uart_echo_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rs232_rx,
  output logic                          rs232_tx,
  input  logic                          echo_en,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_frame,
  output logic                          err_parity,
  output logic                          err_overflow
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);
  localparam parity_e PMODE = parity_e'(2'(PARITY));

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;

  uart_rx_fsm #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (DATA_BITS),
    .PARITY    (PARITY)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rs232_rx   (rs232_rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .err_frame  (err_frame),
    .err_parity (err_parity)
  );

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 full, empty, pop, do_push;

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  // Pop is evaluated first, so a full FIFO still accepts a same-cycle push.
  assign do_push    = rx_valid && (!full || pop);
  assign fifo_level = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
    end else begin
      err_overflow <= rx_valid && full && !pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  tx_state_e            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [3:0]           tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 stop_idx;
  logic                 tx_tick, last_stop;

  assign tx_tick   = (tx_cnt == BIT_LAST);
  assign last_stop = (tx_state == TX_STOP) && tx_tick && (stop_idx == 1'(STOP_BITS - 1));
  // Popping at the end of the last stop bit gives gap-free back-to-back frames.
  assign pop       = echo_en && !empty && ((tx_state == TX_IDLE) || last_stop);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      stop_idx <= 1'b0;
      rs232_tx <= 1'b1;
      tx_busy  <= 1'b0;
    end else if (pop) begin
      tx_state <= TX_START;
      tx_cnt   <= '0;
      tx_shift <= mem[rd_ptr];
      tx_par   <= parity_bit(MAX_DATA_BITS'(mem[rd_ptr]), PMODE);
      rs232_tx <= 1'b0;
      tx_busy  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          rs232_tx <= 1'b1;
          tx_busy  <= 1'b0;
        end
        TX_START: begin
          if (tx_tick) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
            rs232_tx <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt   <= '0;
            tx_shift <= tx_shift >> 1;
            if (tx_idx == 4'(DATA_BITS - 1)) begin
              stop_idx <= 1'b0;
              if (PMODE == PARITY_NONE) begin
                tx_state <= TX_STOP;
                rs232_tx <= 1'b1;
              end else begin
                tx_state <= TX_PARITY;
                rs232_tx <= tx_par;
              end
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              rs232_tx <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_PARITY: begin
          if (tx_tick) begin
            tx_cnt   <= '0;
            stop_idx <= 1'b0;
            tx_state <= TX_STOP;
            rs232_tx <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              tx_state <= TX_IDLE;
              tx_busy  <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
